nand_cmd_sequencer: RTL and testbench
=====================================

NAND_CMD_SEQUENCER -- requirements
Module: nand_cmd_sequencer

Interface
REQ-001 SHALL have parameter NUM_CE, default 8, number of chip enables / R/B lines on one bus.
REQ-002 SHALL have parameter T_WP, default 2, WE# low width in CLK cycles (min 1).
REQ-003 SHALL have parameter T_WH, default 2, WE# high hold width in CLK cycles (min 1).
REQ-004 SHALL have parameter T_WB, default 10, cycles from last WE# rise before R/B# is sampled.
REQ-005 SHALL have parameter RB_TIMEOUT, default 1000000, busy-wait limit in cycles (used only under RB_TIMEOUT_EN).
REQ-006 SHALL have port CLK  in  1  single clock; all logic on rising edge.
REQ-007 SHALL have port RST_N  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port req_valid  in  1  request strobe.
REQ-009 SHALL have port req_ready  out  1  high exactly when in IDLE.
REQ-010 SHALL have port req_ce  in  3  target chip-enable index.
REQ-011 SHALL have port req_cmd0  in  8  first command byte.
REQ-012 SHALL have port req_naddr  in  3  address byte count, 0-5.
REQ-013 SHALL have port req_addr  in  40  address bytes, byte 0 = [7:0].
REQ-014 SHALL have port req_cmd1_en  in  1  issue second command byte.
REQ-015 SHALL have port req_cmd1  in  8  second command byte.
REQ-016 SHALL have port req_wait_rb  in  1  wait for R/B# ready before completing.
REQ-017 SHALL have port done_valid  out  1  one-cycle completion pulse.
REQ-018 SHALL have port done_err  out  1  error qualifier, valid with done_valid.
REQ-019 SHALL have ports nand_cen out NUM_CE, nand_cle out 1, nand_ale out 1, nand_wen out 1, nand_dq_o out 8, nand_dq_oe out 1, nand_rb in NUM_CE (open-drain R/B#, low = busy).

Function
REQ-020 SHALL accept a request on the cycle req_valid && req_ready, capturing all req_* fields into registers.
REQ-021 SHALL implement states IDLE, CMD0, ADDR, CMD1, WAIT_WB, WAIT_RB, DONE.
REQ-022 SHALL run each latch cycle as T_WP cycles wen=0 then T_WH cycles wen=1, with dq_o/cle/ale stable across both and dq_oe=1.
REQ-023 SHALL drive cle=1, ale=0 in CMD0/CMD1; cle=0, ale=1 in ADDR; cle=ale=0 elsewhere.
REQ-024 SHALL send address bytes LSB first, byte index 0..naddr-1; req_naddr>5 SHALL be clamped to 5; naddr=0 skips ADDR.
REQ-025 SHALL skip CMD1 when req_cmd1_en=0; after last latch cycle go to WAIT_WB if req_wait_rb=1, else DONE.
REQ-026 SHALL hold nand_cen[req_ce]=0 from CMD0 entry until leaving DONE; all other CE bits stay 1.
REQ-027 SHALL wait T_WB cycles in WAIT_WB, then in WAIT_RB sample nand_rb[req_ce] through a 2-flop synchronizer and go to DONE on first synchronized 1.
REQ-028 SHALL assert done_valid for exactly one cycle in DONE, then return to IDLE the next cycle.
REQ-029 SHALL, when req_ce >= NUM_CE, assert no CE and no WE# pulse, and complete in DONE with done_err=1 on the cycle after acceptance.
REQ-030 SHALL ignore req_valid while req_ready=0; no queuing.
REQ-031 SHALL set dq_oe=0 outside CMD0/ADDR/CMD1.

Reset
REQ-032 SHALL, on RST_N low at any time including mid-operation, immediately force: state IDLE, nand_cen all 1, nand_cle 0, nand_ale 0, nand_wen 1, nand_dq_o 0x00, nand_dq_oe 0, done_valid 0, done_err 0, counters 0; req_ready SHALL read 1 after release.
REQ-033 SHALL NOT emit done_valid for an operation aborted by reset.

Configuration
REQ-034 SHALL, with RB_TIMEOUT_EN defined, count cycles in WAIT_RB and on reaching RB_TIMEOUT enter DONE with done_err=1.
REQ-035 SHALL, without RB_TIMEOUT_EN, wait in WAIT_RB indefinitely, have no timeout counter, and set done_err only per REQ-029.

Verification
REQ-036 SHALL cover Read Page: ce=0, cmd0=0x00, naddr=5, addr=0x0403020100, cmd1=0x30, wait_rb=1, R/B# low 50 cycles -> DQ bytes 00,00,01,02,03,04,30 with cle/ale per REQ-023, 7 WE# pulses each 2 low/2 high, done_valid once, done_err=0.
REQ-037 SHALL cover Reset: ce=3, cmd0=0xFF, naddr=0, cmd1_en=0, wait_rb=1, R/B# already high -> one CLE cycle, done_valid 4+10+2..3 cycles after first wen fall, only nand_cen[3] low.
REQ-038 SHALL cover bad CE: req_ce=7 with NUM_CE=4 -> no CE/WE# activity, done_valid+done_err=1 next cycle.
REQ-039 SHALL cover reset mid-ADDR: RST_N low during byte 2 -> same-cycle wen=1, cen=0xFF, dq_oe=0, no done_valid; new request after release runs normally.
REQ-040 SHALL cover timeout (RB_TIMEOUT_EN, RB_TIMEOUT=100): R/B# held low -> done_err=1 exactly 100 cycles after WAIT_RB entry; without macro, no done_valid.
REQ-041 SHALL cover back-to-back: req_valid held high with two requests -> second accepted only in the IDLE cycle after DONE.

Source files
------------

// File: rtl/nand_cmd_sequencer.sv
// rtl/nand_cmd_sequencer.sv - NAND CMD/ADDR latch sequencer with R/B# wait; `RB_TIMEOUT_EN adds a busy-wait timeout
module nand_cmd_sequencer #(
  parameter int NUM_CE     = 8,
  parameter int T_WP       = 2,
  parameter int T_WH       = 2,
  parameter int T_WB       = 10,
  parameter int RB_TIMEOUT = 1000000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_ce,
  input  logic [7:0]        req_cmd0,
  input  logic [2:0]        req_naddr,
  input  logic [39:0]       req_addr,
  input  logic              req_cmd1_en,
  input  logic [7:0]        req_cmd1,
  input  logic              req_wait_rb,
  output logic              done_valid,
  output logic              done_err,
  output logic [NUM_CE-1:0] nand_cen,
  output logic              nand_cle,
  output logic              nand_ale,
  output logic              nand_wen,
  output logic [7:0]        nand_dq_o,
  output logic              nand_dq_oe,
  input  logic [NUM_CE-1:0] nand_rb
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD0    = 3'd1,
    ADDR    = 3'd2,
    CMD1    = 3'd3,
    WAIT_WB = 3'd4,
    WAIT_RB = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t            state;
  state_t            nxt_latch;
  logic              phase;       // 0: WE# low part of a latch cycle, 1: WE# high part
  logic [15:0]       cnt;
  logic [2:0]        addr_left;   // address bytes still to send after the current one
  logic [39:0]       addr_sh;     // next address byte always sits in [7:0]
  logic              cmd1_en_q;
  logic [7:0]        cmd1_q;
  logic              wait_rb_q;
  logic              rb_s1;
  logic              rb_s2;
  logic              rb_sel;
  logic [NUM_CE-1:0] cen_sel;
  logic              bad_ce;
  logic [2:0]        naddr_clamp;
  logic              latch_end;
`ifdef RB_TIMEOUT_EN
  logic [31:0]       to_cnt;
`endif

  assign req_ready = (state == IDLE);
  // Only the selected CE is low while waiting, so masking R/B# with it picks that die's line.
  assign rb_sel    = |(nand_rb & ~nand_cen);
  assign latch_end = phase && (cnt == 16'(T_WH - 1));

  // Decode the incoming request: CE one-hot (active low), range check, address count clamp.
  always_comb begin
    cen_sel = '1;
    for (int i = 0; i < NUM_CE; i++) begin
      if (int'(req_ce) == i) cen_sel[i] = 1'b0;
    end
    bad_ce      = (int'(req_ce) >= NUM_CE);
    naddr_clamp = (req_naddr > 3'd5) ? 3'd5 : req_naddr;
  end

  // Choose where to go once the current latch cycle finishes.
  always_comb begin
    if ((state == CMD0 || state == ADDR) && addr_left != 3'd0) nxt_latch = ADDR;
    else if (state != CMD1 && cmd1_en_q)                         nxt_latch = CMD1;
    else if (wait_rb_q)                                          nxt_latch = WAIT_WB;
    else                                                         nxt_latch = DONE;
  end

  // Main sequencer: state, request capture and all registered bus outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      phase      <= 1'b0;
      cnt        <= '0;
      addr_left  <= '0;
      addr_sh    <= '0;
      cmd1_en_q  <= 1'b0;
      cmd1_q     <= '0;
      wait_rb_q  <= 1'b0;
      nand_cen   <= '1;
      nand_cle   <= 1'b0;
      nand_ale   <= 1'b0;
      nand_wen   <= 1'b1;
      nand_dq_o  <= '0;
      nand_dq_oe <= 1'b0;
      done_valid <= 1'b0;
      done_err   <= 1'b0;
`ifdef RB_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cmd1_en_q <= req_cmd1_en;
            cmd1_q    <= req_cmd1;
            wait_rb_q <= req_wait_rb;
            addr_sh   <= req_addr;
            addr_left <= naddr_clamp;
            cnt       <= '0;
            phase     <= 1'b0;
            if (bad_ce) begin
              // Nonexistent die: finish immediately without touching the bus.
              state      <= DONE;
              done_valid <= 1'b1;
              done_err   <= 1'b1;
            end else begin
              state      <= CMD0;
              nand_cen   <= cen_sel;
              nand_cle   <= 1'b1;
              nand_ale   <= 1'b0;
              nand_dq_o  <= req_cmd0;
              nand_dq_oe <= 1'b1;
              nand_wen   <= 1'b0;
            end
          end
        end
        CMD0, ADDR, CMD1: begin
          if (!phase) begin
            if (cnt == 16'(T_WP - 1)) begin
              phase    <= 1'b1;
              cnt      <= '0;
              nand_wen <= 1'b1;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end else if (!latch_end) begin
            cnt <= cnt + 16'd1;
          end else begin
            state <= nxt_latch;
            phase <= 1'b0;
            cnt   <= '0;
            case (nxt_latch)
              ADDR: begin
                nand_wen  <= 1'b0;
                nand_cle  <= 1'b0;
                nand_ale  <= 1'b1;
                nand_dq_o <= addr_sh[7:0];
                addr_sh   <= addr_sh >> 8;
                addr_left <= addr_left - 3'd1;
              end
              CMD1: begin
                nand_wen  <= 1'b0;
                nand_cle  <= 1'b1;
                nand_ale  <= 1'b0;
                nand_dq_o <= cmd1_q;
              end
              default: begin
                nand_cle   <= 1'b0;
                nand_ale   <= 1'b0;
                nand_dq_o  <= '0;
                nand_dq_oe <= 1'b0;
                if (nxt_latch == DONE) begin
                  done_valid <= 1'b1;
                  done_err   <= 1'b0;
                end
              end
            endcase
          end
        end
        WAIT_WB: begin
          if (cnt == 16'(T_WB - 1)) begin
            state <= WAIT_RB;
            cnt   <= '0;
`ifdef RB_TIMEOUT_EN
            to_cnt <= '0;
`endif
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WAIT_RB: begin
          if (rb_s2) begin
            state      <= DONE;
            done_valid <= 1'b1;
            done_err   <= 1'b0;
          end
`ifdef RB_TIMEOUT_EN
          else if (to_cnt == 32'(RB_TIMEOUT - 1)) begin
            state      <= DONE;
            done_valid <= 1'b1;
            done_err   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
`endif
        end
        DONE: begin
          state      <= IDLE;
          done_valid <= 1'b0;
          done_err   <= 1'b0;
          nand_cen   <= '1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // R/B# synchronizer, held clear outside WAIT_RB so a stale ready level never completes early.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rb_s1 <= 1'b0;
      rb_s2 <= 1'b0;
    end else if (state == WAIT_RB) begin
      rb_s1 <= rb_sel;
      rb_s2 <= rb_s1;
    end else begin
      rb_s1 <= 1'b0;
      rb_s2 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nand_cmd_sequencer.sv
// tb/tb_nand_cmd_sequencer.sv - directed self-checking bench for nand_cmd_sequencer (NUM_CE=4, RB_TIMEOUT=100)
module tb_nand_cmd_sequencer;
  localparam int NCE = 4;

  logic           CLK = 1'b0;
  logic           RST_N = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [2:0]     req_ce = '0;
  logic [7:0]     req_cmd0 = '0;
  logic [2:0]     req_naddr = '0;
  logic [39:0]    req_addr = '0;
  logic           req_cmd1_en = 1'b0;
  logic [7:0]     req_cmd1 = '0;
  logic           req_wait_rb = 1'b0;
  logic           done_valid;
  logic           done_err;
  logic [NCE-1:0] nand_cen;
  logic           nand_cle;
  logic           nand_ale;
  logic           nand_wen;
  logic [7:0]     nand_dq_o;
  logic           nand_dq_oe;
  logic [NCE-1:0] nand_rb = '1;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  nand_cmd_sequencer #(.NUM_CE(NCE), .RB_TIMEOUT(100)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_ce(req_ce), .req_cmd0(req_cmd0),
    .req_naddr(req_naddr), .req_addr(req_addr), .req_cmd1_en(req_cmd1_en), .req_cmd1(req_cmd1),
    .req_wait_rb(req_wait_rb), .done_valid(done_valid), .done_err(done_err),
    .nand_cen(nand_cen), .nand_cle(nand_cle), .nand_ale(nand_ale), .nand_wen(nand_wen),
    .nand_dq_o(nand_dq_o), .nand_dq_oe(nand_dq_oe), .nand_rb(nand_rb)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Bus monitor: one entry per WE# pulse plus run lengths of the low and inter-pulse high phases.
  logic [7:0] q_dq[$];
  logic [1:0] q_cl[$];
  int q_low[$];
  int q_high[$];
  int q_fall[$];
  int low_run = 0, high_run = 0, done_cnt = 0, cen_act = 0, oe_bad = 0, stab_bad = 0;
  logic prev_wen = 1'b1, prev_act = 1'b0;

  always @(negedge CLK) begin
    if (done_valid) done_cnt++;
    if (nand_cen != '1) cen_act++;
    if (!nand_wen) begin
      if (!nand_dq_oe) oe_bad++;
      if (prev_wen) begin
        if (prev_act) q_high.push_back(high_run);
        q_dq.push_back(nand_dq_o);
        q_cl.push_back({nand_cle, nand_ale});
        q_fall.push_back(cyc);
        low_run = 1;
      end else begin
        low_run++;
        if (nand_dq_o != q_dq[$] || {nand_cle, nand_ale} != q_cl[$]) stab_bad++;
      end
    end else begin
      if (!prev_wen) begin
        q_low.push_back(low_run);
        high_run = 1;
      end else begin
        high_run++;
      end
      if ((nand_cle || nand_ale) && q_dq.size() > 0 &&
          (nand_dq_o != q_dq[$] || {nand_cle, nand_ale} != q_cl[$])) stab_bad++;
    end
    prev_wen = nand_wen;
    prev_act = nand_cle || nand_ale;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic issue(input logic [2:0] ce, input logic [7:0] c0, input logic [2:0] na,
                       input logic [39:0] ad, input logic c1e, input logic [7:0] c1, input logic wrb);
    int n = 0;
    req_ce = ce; req_cmd0 = c0; req_naddr = na; req_addr = ad;
    req_cmd1_en = c1e; req_cmd1 = c1; req_wait_rb = wrb; req_valid = 1'b1;
    while (!req_ready && n < 200) begin @(negedge CLK); n++; end
    check("accept_ready", req_ready, 1);
    @(negedge CLK);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int dcyc, output logic derr);
    int n = 0;
    @(negedge CLK);
    while (!done_valid && n < limit) begin @(negedge CLK); n++; end
    check("done_seen", done_valid, 1);
    dcyc = cyc;
    derr = done_err;
  endtask

  logic [7:0] rp_dq [7] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h30};
  logic [1:0] rp_cl [7] = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
  logic [2:0] bad_ces [2] = '{3'd4, 3'd7};

  initial begin
    int b, bl, bh, dc, ca, dcyc, d1, n;
    logic derr, rdy_at_done;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_outs", {req_ready, nand_cen, nand_cle, nand_ale, nand_wen, nand_dq_o, nand_dq_oe, done_valid, done_err},
          {1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0});
    RST_N = 1'b1;
    @(negedge CLK);
    check("rst_ready_after", req_ready, 1);

    // Read Page on CE0: 00 / 5 addr bytes / 30, R/B# busy for 50 cycles
    nand_rb = 4'hE;
    b = q_dq.size(); bl = q_low.size(); bh = q_high.size(); dc = done_cnt;
    issue(3'd0, 8'h00, 3'd5, 40'h0403020100, 1'b1, 8'h30, 1'b1);
    check("rp_cen", nand_cen, 4'b1110);
    check("rp_busy_ready", req_ready, 0);
    repeat (49) @(negedge CLK);
    check("rp_nodone_busy", done_cnt - dc, 0);
    check("rp_wait_lines", {nand_cle, nand_ale, nand_dq_oe, nand_wen, nand_dq_o}, {4'b0001, 8'h00});
    nand_rb = 4'hF;
    wait_done(200, dcyc, derr);
    check("rp_err", derr, 0);
    @(negedge CLK);
    check("rp_idle", {done_valid, req_ready, nand_cen}, {1'b0, 1'b1, 4'hF});
    repeat (2) @(negedge CLK);
    check("rp_npulse", q_dq.size() - b, 7);
    check("rp_ndone", done_cnt - dc, 1);
    if (q_dq.size() >= b + 7) begin
      for (int i = 0; i < 7; i++) begin
        check($sformatf("rp_dq%0d", i), q_dq[b + i], rp_dq[i]);
        check($sformatf("rp_cl%0d", i), q_cl[b + i], rp_cl[i]);
        check($sformatf("rp_twp%0d", i), q_low[bl + i], 2);
      end
      for (int i = 0; i < 6; i++) check($sformatf("rp_twh%0d", i), q_high[bh + i], 2);
    end

    // Reset command on CE3, R/B# already ready: done 4 + 10 + 2..3 cycles after first WE# fall
    b = q_dq.size(); dc = done_cnt;
    issue(3'd3, 8'hFF, 3'd0, 40'h0, 1'b0, 8'h00, 1'b1);
    check("rc_cen", nand_cen, 4'b0111);
    wait_done(100, dcyc, derr);
    check("rc_err", derr, 0);
    repeat (2) @(negedge CLK);
    check("rc_npulse", q_dq.size() - b, 1);
    if (q_dq.size() > b) begin
      check("rc_dq", {q_cl[b], q_dq[b]}, {2'b10, 8'hFF});
      check("rc_latency_16_17", ((dcyc - q_fall[b]) >= 16) && ((dcyc - q_fall[b]) <= 17), 1);
    end
    check("rc_ndone", done_cnt - dc, 1);

    // Bad CE (>= NUM_CE): no bus activity, done+err on the cycle after acceptance
    foreach (bad_ces[k]) begin
      b = q_dq.size(); ca = cen_act;
      issue(bad_ces[k], 8'h00, 3'd5, 40'h0403020100, 1'b1, 8'h30, 1'b1);
      check($sformatf("bad%0d_done", bad_ces[k]), {done_valid, done_err, nand_cen, nand_wen}, {2'b11, 4'hF, 1'b1});
      @(negedge CLK);
      check($sformatf("bad%0d_after", bad_ces[k]), {done_valid, req_ready}, 2'b01);
      check($sformatf("bad%0d_nobus", bad_ces[k]), {q_dq.size() - b, cen_act - ca}, 0);
    end

    // Reset asserted mid-ADDR (address byte 2) aborts with no completion
    dc = done_cnt;
    issue(3'd1, 8'h80, 3'd5, 40'h4433221100, 1'b1, 8'h10, 1'b0);
    n = 0;
    while (!(nand_ale && !nand_wen && nand_dq_o == 8'h22) && n < 50) begin @(negedge CLK); n++; end
    check("mid_byte2_seen", {nand_ale, nand_wen, nand_dq_o}, {2'b10, 8'h22});
    #2 RST_N = 1'b0;
    #1 check("mid_rst_outs", {nand_wen, nand_cen, nand_dq_oe, nand_cle, nand_ale, nand_dq_o, done_valid, req_ready},
             {1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1});
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (20) @(negedge CLK);
    check("mid_no_done", done_cnt - dc, 0);
    b = q_dq.size();
    issue(3'd1, 8'hFF, 3'd0, 40'h0, 1'b0, 8'h00, 1'b0);
    check("mid_new_cen", nand_cen, 4'b1101);
    wait_done(50, dcyc, derr);
    check("mid_new_err", derr, 0);
    repeat (2) @(negedge CLK);
    check("mid_new_pulse", {q_dq.size() - b, q_dq[$]}, {32'd1, 8'hFF});

    // R/B# stuck busy on CE2
    nand_rb = 4'hB;
    b = q_dq.size(); dc = done_cnt;
    issue(3'd2, 8'hFF, 3'd0, 40'h0, 1'b0, 8'h00, 1'b1);
`ifdef RB_TIMEOUT_EN
    wait_done(400, dcyc, derr);
    check("to_err", derr, 1);
    if (q_dq.size() > b) check("to_latency", dcyc - q_fall[b], 4 + 10 + 100);
`else
    repeat (300) @(negedge CLK);
    check("to_no_done", {done_cnt - dc, 31'b0, req_ready}, 0);
    nand_rb = 4'hF;
    wait_done(20, dcyc, derr);
    check("to_late_err", derr, 0);
`endif
    nand_rb = 4'hF;
    repeat (3) @(negedge CLK);

    // Back-to-back with req_valid held: second accept only in the IDLE cycle after DONE
    b = q_dq.size(); dc = done_cnt;
    req_ce = 3'd0; req_cmd0 = 8'hA1; req_naddr = 3'd0; req_cmd1_en = 1'b0; req_wait_rb = 1'b0;
    req_valid = 1'b1;
    @(negedge CLK);
    req_cmd0 = 8'hB2;
    d1 = -1; rdy_at_done = 1'b1; n = 0;
    while (n < 50) begin
      @(negedge CLK); n++;
      if (done_valid && d1 < 0) begin d1 = cyc; rdy_at_done = req_ready; end
      else if (d1 >= 0 && !nand_wen) break;
    end
    req_valid = 1'b0;
    check("b2b_ready_in_done", rdy_at_done, 0);
    check("b2b_accept_gap", cyc - d1, 2);
    wait_done(50, dcyc, derr);
    check("b2b_err2", derr, 0);
    repeat (10) @(negedge CLK);
    check("b2b_npulse", q_dq.size() - b, 2);
    check("b2b_ndone", done_cnt - dc, 2);
    if (q_dq.size() >= b + 2) check("b2b_order", {q_dq[b], q_dq[b + 1]}, 16'hA1B2);

    check("bus_oe_during_wen", oe_bad, 0);
    check("bus_stable", stab_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
